// File: rtl/midi_tx_fsm.sv
// MIDI serial transmitter: frames note on/off, program change and system
// reset messages as 8N1 bytes at BIT_DIV CE-cycles per bit, with optional
// running-status suppression of repeated channel status bytes.
module midi_tx_fsm #(
    parameter int unsigned BIT_DIV  = 1600,
    parameter bit          RUN_STAT = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [3:0] CHANNEL,
    input  logic [1:0] CMD,
    input  logic [6:0] ARG1,
    input  logic [6:0] ARG2,
    input  logic       START,
    output logic       READY,
    output logic       TX,
    output logic [2:0] STATUS
);

    localparam int unsigned   BW        = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        SEND_STAT = 3'b001,
        SEND_D1   = 3'b010,
        SEND_D2   = 3'b011,
        DONE      = 3'b100
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;

    logic [1:0]    cmd_q;
    logic [6:0]    arg1_q;
    logic [6:0]    arg2_q;
    logic [7:0]    stat_q;

    logic [7:0]    last_stat;
    logic          stat_valid;

    logic [7:0]    new_stat;
    logic          accept;
    logic          skip_stat;
    logic          sending;
    logic          byte_end;
    logic [7:0]    cur_byte;
    logic [2:0]    data_idx;

    // Status byte for the command on the inputs and the acceptance decision
    always_comb begin
        new_stat = 8'hFF;
        case (CMD)
            2'b00:   new_stat = {4'h8, CHANNEL};
            2'b01:   new_stat = {4'h9, CHANNEL};
            2'b10:   new_stat = {4'hC, CHANNEL};
            default: new_stat = 8'hFF;
        endcase
        accept    = CE && START && (state == IDLE);
        // System reset is never a running-status candidate
        skip_stat = RUN_STAT && stat_valid && (new_stat == last_stat) && (CMD != 2'b11);
        sending   = (state == SEND_STAT) || (state == SEND_D1) || (state == SEND_D2);
        byte_end  = CE && sending && (baud_cnt == BAUD_LAST) && (bit_cnt == 4'd9);
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic: message length depends on the latched command
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept)   state_next = skip_stat ? SEND_D1 : SEND_STAT;
            SEND_STAT: if (byte_end) state_next = (cmd_q == 2'b11) ? DONE : SEND_D1;
            SEND_D1:   if (byte_end) state_next = (cmd_q == 2'b10) ? DONE : SEND_D2;
            SEND_D2:   if (byte_end) state_next = DONE;
            DONE:      if (CE)       state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Baud and bit counters; cleared whenever no byte is being shifted out
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (CE) begin
            if (!sending) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                bit_cnt  <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

    // Message capture at acceptance so later input changes cannot leak in
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cmd_q  <= '0;
            arg1_q <= '0;
            arg2_q <= '0;
            stat_q <= '1;
        end else if (accept) begin
            cmd_q  <= CMD;
            arg1_q <= ARG1;
            arg2_q <= ARG2;
            stat_q <= new_stat;
        end
    end

    // Running-status memory: set after a channel status byte completes,
    // cleared by a system reset request
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_stat  <= '0;
            stat_valid <= 1'b0;
        end else if (accept && (CMD == 2'b11)) begin
            stat_valid <= 1'b0;
        end else if ((state == SEND_STAT) && byte_end && (cmd_q != 2'b11)) begin
            last_stat  <= stat_q;
            stat_valid <= 1'b1;
        end
    end

    // Serial line: start bit, LSB-first data, stop bit; idle high otherwise
    always_comb begin
        case (state)
            SEND_D1: cur_byte = {1'b0, arg1_q};
            SEND_D2: cur_byte = {1'b0, arg2_q};
            default: cur_byte = stat_q;
        endcase
        data_idx = bit_cnt[2:0] - 3'd1;
        TX       = 1'b1;
        if (sending) begin
            if (bit_cnt == 4'd0)      TX = 1'b0;
            else if (bit_cnt <= 4'd8) TX = cur_byte[data_idx];
        end
    end

    assign READY  = (state == IDLE);
    assign STATUS = state;

endmodule

// File: doc/midi_tx_fsm.md
MIDI_TX_FSM -- requirements
Module: midi_tx_fsm

Interface
REQ-001 Parameter: BIT_DIV, default 1600, CE-qualified clock cycles per serial bit (50 MHz / 31250 baud).
REQ-002 Parameter: RUN_STAT, default 1, 1 enables running-status suppression.
REQ-003 Port: CLK  input  1  system clock; all state on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-low.
REQ-005 Port: CE  input  1  clock enable; when low, all state, counters and outputs hold.
REQ-006 Port: CHANNEL  input  4  MIDI channel inserted into status low nibble.
REQ-007 Port: CMD  input  2  00 note off (0x8n), 01 note on (0x9n), 10 program change (0xCn), 11 system reset (0xFF).
REQ-008 Port: ARG1  input  7  note number or program number.
REQ-009 Port: ARG2  input  7  velocity; ignored for CMD 10/11.
REQ-010 Port: START  input  1  request; accepted only when READY=1 and CE=1.
REQ-011 Port: READY  output  1  high when idle and able to accept START.
REQ-012 Port: TX  output  1  serial MIDI line, idle high.
REQ-013 Port: STATUS  output  3  current FSM state code.

Function
REQ-014 FSM states and STATUS codes SHALL be: IDLE 000, SEND_STAT 001, SEND_D1 010, SEND_D2 011, DONE 100; unused codes return to IDLE.
REQ-015 On acceptance, CHANNEL, CMD, ARG1, ARG2 SHALL be latched; later input changes SHALL not affect the message in flight.
REQ-016 READY SHALL fall on the clock edge that accepts START and stay low until DONE completes.
REQ-017 START while READY=0 SHALL be ignored, with no queueing.
REQ-018 Each byte SHALL be framed as start bit 0, eight data bits LSB first, stop bit 1; each bit SHALL last exactly BIT_DIV CE-enabled cycles.
REQ-019 The start bit of the first byte SHALL appear on TX the CE-cycle after acceptance.
REQ-020 Bytes within one message SHALL be back-to-back, with no idle gap beyond the stop bit.
REQ-021 Data bytes SHALL be {0,ARG1} then {0,ARG2}; bit 7 is always 0.
REQ-022 Message lengths SHALL be: note on/off 3 bytes, program change 2 bytes (SEND_D1 to DONE), system reset 1 byte 0xFF (SEND_STAT to DONE).
REQ-023 Running status: with RUN_STAT=1, if the new status byte equals the last transmitted status byte and a valid flag is set, the FSM SHALL skip SEND_STAT (IDLE to SEND_D1) and the first data byte's start bit SHALL appear the CE-cycle after acceptance.
REQ-024 After each transmitted channel status byte, the last-status register SHALL be updated and the valid flag set.
REQ-025 CMD 11 SHALL always be transmitted (never suppressed) and SHALL clear the valid flag.
REQ-026 With RUN_STAT=0, the status byte SHALL always be sent.
REQ-027 DONE SHALL last one CE-cycle, then go to IDLE with READY=1; a START in that IDLE cycle is accepted normally.
REQ-028 Velocity 0 note-on SHALL be sent unchanged, with no conversion to note-off.

Reset
REQ-029 RST low SHALL immediately, without waiting for CLK, force state IDLE, TX=1, READY=1, STATUS=000, baud and bit counters to 0, running-status valid flag to 0.
REQ-030 Reset mid-byte SHALL abort the message; TX SHALL return high immediately, and the next message after release SHALL include its status byte.
REQ-031 Reset SHALL take effect regardless of CE.

Verification (BIT_DIV=4, RUN_STAT=1 unless stated)
REQ-032 CMD=01, CHANNEL=3, ARG1=0x3C, ARG2=0x64, START -> TX bytes 0x93, 0x3C, 0x64, 120 cycles of framed data, READY high after DONE.
REQ-033 Second identical note-on immediately after the first -> bytes 0x3C, 0x64 only, 80 cycles; with RUN_STAT=0 -> 3 bytes.
REQ-034 CMD=10, ARG1=0x05, CHANNEL=0, then CMD=11, then CMD=10 again -> 0xC0 0x05, 0xFF, 0xC0 0x05, with status resent after reset byte.
REQ-035 CE toggled 1-of-3 during a note-on -> identical bit sequence, each bit stretched to 12 clocks; START pulsed while busy -> ignored.
REQ-036 RST asserted mid-second byte -> TX=1 and READY=1 asynchronously; next note-on after release sends full 3 bytes.
